// File: rtl/histogram_builder.sv
// Grey-level histogram builder: clears the shared histogram RAM, then performs a
// pipelined read-modify-write (+1) per accepted pixel and reports frame completion.
module histogram_builder #(
  parameter int DATA_W = 20,
  parameter int BIN_W  = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [BIN_W-1:0]  iPixel,
  input  logic              iValid,
  input  logic              iFrameEnd,
  output logic              oReady,
  output logic [BIN_W-1:0]  oRdAddr,
  input  logic [DATA_W-1:0] iRdQ,
  output logic [BIN_W-1:0]  oWrAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oWE,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oPixelCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] CNT_MAX  = '1;
  localparam logic [BIN_W-1:0]  ADDR_MAX = '1;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t             state;
  logic [BIN_W-1:0]   clr_addr;
  logic [DATA_W-1:0]  pix_cnt;
  logic               ready;
  logic               busy;
  logic               done;

  logic               accept;
  logic               vld_p1;
  logic [BIN_W-1:0]   pix_p1;
  logic [DATA_W-1:0]  base_p1;
  logic [DATA_W-1:0]  new_p1;
  logic               inc_we;

  logic               fwd_vld_p2;
  logic [BIN_W-1:0]   fwd_addr_p2;
  logic [DATA_W-1:0]  fwd_data_p2;

  // Stage 0: issue the bin read for an accepted pixel
  assign accept  = (state == S_ACCUM) && iValid && !iStart;
  assign oRdAddr = accept ? iPixel : '0;

  // Stage 1: increment the read value; a write to the same bin in the previous
  // cycle is not yet visible on iRdQ, so its data is forwarded instead
  assign inc_we  = vld_p1 && ((state == S_ACCUM) || (state == S_DRAIN));
  assign base_p1 = (fwd_vld_p2 && (fwd_addr_p2 == pix_p1)) ? fwd_data_p2 : iRdQ;
  assign new_p1  = sat_inc(base_p1);

  assign oWE     = (state == S_CLEAR) || inc_we;
  assign oWrAddr = (state == S_CLEAR) ? clr_addr : (inc_we ? pix_p1 : '0);
  assign oWrData = ((state != S_CLEAR) && inc_we) ? new_p1 : '0;

  assign oReady      = ready;
  assign oBusy       = busy;
  assign oDone       = done;
  assign oPixelCount = pix_cnt;

  always_ff @(posedge iClk) begin
    if (accept) pix_p1 <= iPixel;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= S_IDLE;
      clr_addr    <= '0;
      pix_cnt     <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vld_p1      <= 1'b0;
      fwd_vld_p2  <= 1'b0;
      fwd_addr_p2 <= '0;
      fwd_data_p2 <= '0;
    end else begin
      vld_p1     <= accept;
      fwd_vld_p2 <= inc_we && !iStart;
      if (inc_we) begin
        fwd_addr_p2 <= pix_p1;
        fwd_data_p2 <= new_p1;
      end
      if (accept) pix_cnt <= sat_inc(pix_cnt);

      // A start pulse from any state (re)starts the clear and drops the frame
      if (iStart) begin
        state    <= S_CLEAR;
        clr_addr <= '0;
        pix_cnt  <= '0;
        ready    <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == ADDR_MAX) begin
              state <= S_ACCUM;
              ready <= 1'b1;
            end
          end
          S_ACCUM: begin
            if (iFrameEnd) begin
              state <= S_DRAIN;
              ready <= 1'b0;
            end
          end
          S_DRAIN: begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          S_IDLE, S_DONE: ;
          default: begin
            state <= S_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_histogram_builder.sv
// Directed bench for histogram_builder with a behavioural dual-port RAM whose
// mixed-port read-during-write returns the old word.
module tb_histogram_builder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pixel;
  logic        valid;
  logic        frame_end;
  logic        ready;
  logic [7:0]  rd_addr;
  logic [19:0] rd_q;
  logic [7:0]  wr_addr;
  logic [19:0] wr_data;
  logic        we;
  logic        busy;
  logic        done;
  logic [19:0] pix_cnt;

  logic [19:0] mem  [256];
  logic [19:0] hist [256];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [19:0] tb_data;

  int n_chk;
  int n_pass;

  histogram_builder #(.DATA_W(20), .BIN_W(8)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iPixel(pixel), .iValid(valid),
    .iFrameEnd(frame_end), .oReady(ready), .oRdAddr(rd_addr), .iRdQ(rd_q),
    .oWrAddr(wr_addr), .oWrData(wr_data), .oWE(we), .oBusy(busy), .oDone(done),
    .oPixelCount(pix_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_q <= mem[rd_addr];
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (we) mem[wr_addr] <= wr_data;
  end

  typedef struct {
    logic [63:0] pix;
    int          n;
    logic [7:0]  vmask;
    bit          fe_last;
    logic [7:0]  bin_a;
    int          exp_a;
    logic [7:0]  bin_b;
    int          exp_b;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) hist[i] = '0;
  endtask

  task automatic compare_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== hist[i]) bad++;
    check({tag, " bins_wrong"}, bad, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!ready && k < 400) begin
      step();
      k++;
    end
    check({tag, " ready_after_clear"}, ready, 1);
    clear_model();
  endtask

  task automatic model_pixel(input logic [7:0] p);
    if (hist[p] != 20'hFFFFF) hist[p] = hist[p] + 20'd1;
  endtask

  task automatic feed_frame(input logic [63:0] pix, input int n, input logic [7:0] vmask,
                            input bit fe_last);
    for (int i = 0; i < n; i++) begin
      pixel     = pix[8*i +: 8];
      valid     = vmask[i];
      frame_end = fe_last && (i == n - 1);
      if (valid) model_pixel(pixel);
      step();
    end
    valid = 1'b0;
    if (!(fe_last && n > 0)) begin
      frame_end = 1'b1;
      step();
    end
    frame_end = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    check({tag, " done_in_drain"}, done, 0);
    step();
    check({tag, " done_after_2"}, done, 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " we_in_done"}, we, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, ready, 0);
    check({tag, " we"}, we, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " pix_cnt"}, pix_cnt, 0);
  endtask

  initial begin
    int wc, bad, sent, cyc, sum, k;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; pixel = 8'd5; valid = 1'b1; frame_end = 1'b0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;

    vecs[0] = '{64'h0000_0025_2525_2525, 5, 8'hFF, 1'b0, 8'd37, 5, 8'd36, 0, 5};
    vecs[1] = '{64'h0000_000A_0B0A_0B0A, 5, 8'hFF, 1'b1, 8'd10, 3, 8'd11, 2, 5};
    vecs[2] = '{64'h0000_0009_0907_0707, 5, 8'h15, 1'b1, 8'd7,  2, 8'd9,  1, 3};
    vecs[3] = '{64'h0000_0000_FF00_FFFF, 4, 8'hFF, 1'b0, 8'd255, 3, 8'd0, 1, 4};
    vecs[4] = '{64'h0000_0000_0000_0000, 0, 8'h00, 1'b0, 8'd37, 0, 8'd0,  0, 0};
    vecs[5] = '{64'h0000_0032_3232_3232, 5, 8'h1B, 1'b0, 8'd50, 4, 8'd51, 0, 4};

    // Fill RAM with garbage while held in reset
    tb_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tb_addr = 8'(i);
      tb_data = 20'hABCDE ^ 20'(i);
      step();
    end
    tb_we = 1'b0;
    check_all_zero("reset");

    rst_n = 1'b1;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    wc = 0;
    for (int i = 0; i < 5; i++) begin
      if (we || ready || done) wc++;
      step();
    end
    check("idle ignores pixels/frame_end", wc, 0);
    check("idle rd_addr", rd_addr, 0);
    valid = 1'b0;

    // Clear sequence: exactly 256 writes of zero at ascending addresses
    do_start();
    check("clear busy", busy, 1);
    check("clear ready", ready, 0);
    wc = 0; bad = 0;
    for (int i = 0; i < 300 && !ready; i++) begin
      if (we) begin
        if (wr_addr !== wc[7:0] || wr_data !== 20'd0) bad++;
        wc++;
      end
      step();
    end
    check("clear we_cycles", wc, 256);
    check("clear addr_data_errs", bad, 0);
    check("clear then ready", ready, 1);
    clear_model();
    compare_ram("clear");

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_start();
      check({tag, " done_drops"}, done, 0);
      wait_ready(tag);
      check({tag, " cnt_cleared"}, pix_cnt, 0);
      feed_frame(vecs[v].pix, vecs[v].n, vecs[v].vmask, vecs[v].fe_last);
      finish_frame(tag);
      check({tag, " bin_a"}, mem[vecs[v].bin_a], vecs[v].exp_a);
      check({tag, " bin_b"}, mem[vecs[v].bin_b], vecs[v].exp_b);
      check({tag, " pix_cnt"}, pix_cnt, vecs[v].exp_cnt);
      compare_ram(tag);
    end

    // Saturation: bin 200 preloaded just below full scale
    do_start();
    wait_ready("sat");
    tb_we = 1'b1; tb_addr = 8'd200; tb_data = 20'hFFFFE;
    step();
    tb_we = 1'b0;
    hist[200] = 20'hFFFFE;
    feed_frame(64'h0000_0000_00C8_C8C8, 3, 8'hFF, 1'b0);
    finish_frame("sat");
    check("sat bin200", mem[200], 20'hFFFFF);
    check("sat pix_cnt", pix_cnt, 3);
    compare_ram("sat");

    // Abort mid-frame; frame_end during the following clear is ignored
    do_start();
    wait_ready("abort");
    pixel = 8'd60; valid = 1'b1;
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0; valid = 1'b0;
    check("abort busy", busy, 1);
    check("abort ready", ready, 0);
    check("abort pix_cnt", pix_cnt, 0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    wait_ready("abort");
    compare_ram("abort cleared");
    feed_frame(64'h0000_0000_0000_3C3C, 2, 8'hFF, 1'b1);
    finish_frame("abort2");
    check("abort2 bin60", mem[60], 2);
    compare_ram("abort2");

    // Longer frame with random valid gaps and clustered pixel values
    do_start();
    wait_ready("rand");
    sent = 0; cyc = 0;
    while (sent < 3000 && cyc < 20000) begin
      valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pixel = 8'($urandom_range(0, 255));
      else pixel = 8'($urandom_range(0, 7));
      if (valid) begin
        model_pixel(pixel);
        sent++;
      end
      step();
      cyc++;
    end
    valid = 1'b0;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    finish_frame("rand");
    sum = 0;
    for (int i = 0; i < 256; i++) sum += int'(mem[i]);
    check("rand pix_cnt", pix_cnt, 3000);
    check("rand bin_sum", sum, 3000);
    compare_ram("rand");

    // Asynchronous reset during clear
    do_start();
    k = 0;
    while (!(we && wr_addr == 8'd100) && k < 300) begin
      step();
      k++;
    end
    check("rst_mid addr100 reached", wr_addr, 100);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    wc = 0;
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pixel = 8'(i * 17);
      if (we || ready || busy || rd_addr != 8'd0) wc++;
      step();
    end
    valid = 1'b0;
    check("rst_mid idle activity", wc, 0);
    check("rst_mid pix_cnt", pix_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
